// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: memory map constants and the ROM loader state encoding.
package chip8_pkg;
  localparam int          CH8_ADDR_W    = 12;
  localparam logic [11:0] CH8_PROG_BASE = 12'h200;
  localparam int          CH8_RAM_SIZE  = 4096;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE
  } ldr_state_e;
endpackage

// File: rtl/chip8_rom_loader.sv
// Streams a length-prefixed program image into CHIP-8 RAM while holding the CPU.
// Define CH8_LOADER_CHECKSUM_EN to require an 8-bit additive checksum trailer.
module chip8_rom_loader
  import chip8_pkg::*;
#(
  parameter int                ADDR_W    = CH8_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(CH8_PROG_BASE),
  parameter int                MAX_LEN   = CH8_RAM_SIZE - int'(CH8_PROG_BASE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] load_len
);

  ldr_state_e        state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] load_len_q, load_len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              error_q, error_d;
  logic              hold_q, hold_d;
`ifdef CH8_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] len;
  logic        last;

  assign s_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                   (state_q == DATA)   || (state_q == CSUM);
  // abort beats a simultaneous transfer, so the byte is never consumed
  assign accept  = s_valid && s_ready && !abort;
  assign len     = {hi_q, s_data};
  assign last    = (idx_q == load_len_q - ADDR_W'(1));

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    load_len_d = load_len_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;
`ifdef CH8_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      error_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = LEN_HI;
          error_d = 1'b0;
        end
        LEN_HI: if (accept) begin
          hi_d    = s_data;
          state_d = LEN_LO;
        end
        LEN_LO: if (accept) begin
          if (len == 16'd0 || len > 16'(MAX_LEN)) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            load_len_d = len[ADDR_W-1:0];
            idx_d      = '0;
`ifdef CH8_LOADER_CHECKSUM_EN
            sum_d      = 8'd0;
`endif
            state_d    = DATA;
          end
        end
        DATA: if (accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + idx_q;
          wdata_d = s_data;
          idx_d   = idx_q + ADDR_W'(1);
`ifdef CH8_LOADER_CHECKSUM_EN
          sum_d   = sum_q + s_data;
          if (last) state_d = CSUM;
`else
          if (last) state_d = DONE;
`endif
        end
`ifdef CH8_LOADER_CHECKSUM_EN
        CSUM: if (accept) begin
          if (s_data == sum_q) begin
            state_d = DONE;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
`endif
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    hold_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      load_len_q <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      error_q    <= 1'b0;
      hold_q     <= 1'b0;
`ifdef CH8_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      load_len_q <= load_len_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
      hold_q     <= hold_d;
`ifdef CH8_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign busy      = (state_q != IDLE);
  // an abort landing in DONE turns the load into an error, never both
  assign done      = (state_q == DONE) && !abort;
  assign error     = error_q;
  assign load_len  = load_len_q;

endmodule

// File: doc/chip8_rom_loader.md
Name: chip8_rom_loader

Overview:
- Writer side of the CHIP-8 program RAM; the CPU fetch engine is the reader.
- Accepts a framed byte stream (valid/ready) from a host link, e.g. a UART receiver, and writes the payload into RAM starting at the program base.
- Holds the CPU in reset while loading and flags completion or error.

Parameters:
- ADDR_W, 12, RAM address width (4 KiB).
- BASE_ADDR, 12'h200, RAM address of the first payload byte.
- MAX_LEN, 3584, largest payload accepted (4096 - 0x200); guarantees no address wrap.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a load; sampled in IDLE only
- abort  input  1  cancel an in-progress load
- s_data  input  8  stream byte
- s_valid  input  1  s_data valid
- s_ready  output  1  loader accepts byte this cycle
- ram_we  output  1  RAM write strobe
- ram_addr  output  ADDR_W  RAM write address
- ram_wdata  output  8  RAM write data
- cpu_hold  output  1  keeps CPU in reset/fetch-stalled
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse on successful load
- error  output  1  sticky; cleared on accepted start
- load_len  output  ADDR_W  last header length, registered

Behaviour:
- Reset: asynchronous and active-high. On reset, state = IDLE and all outputs = 0, including ram_we; any in-flight write is dropped. Reset mid-load leaves RAM partially written; no recovery is attempted.
- Frame: LEN_HI byte, LEN_LO byte (big-endian 16-bit length), payload of length bytes, then a checksum byte if the optional feature is compiled in.
- Handshake: a byte transfers on cycle(s_valid && s_ready). s_ready = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in IDLE and DONE. s_data is never consumed without s_ready.
- States:
  - IDLE: start -> LEN_HI, clear error, cpu_hold <= 1.
  - LEN_HI: accept -> LEN_LO.
  - LEN_LO: accept -> check the 16-bit length.
    - Length 0 or > MAX_LEN: error <= 1, -> IDLE.
    - Otherwise: load_len <= length, index <= 0, -> DATA.
  - DATA: each accept writes the byte to RAM (see write timing) and increments index. The accept with index == length-1 -> CSUM if enabled, else DONE.
  - DONE: done = 1 for exactly one cycle, -> IDLE.
  - IDLE (after DONE or error): cpu_hold = 0.
- Write timing: ram_we, ram_addr and ram_wdata are registered, asserted the cycle after the accept. ram_addr = BASE_ADDR + index, computed modulo 2^ADDR_W (the MAX_LEN check makes overflow impossible). Back-to-back accepts give back-to-back writes; throughput is 1 byte/cycle.
- abort:
  - In any non-IDLE state: -> IDLE, error <= 1, cpu_hold <= 0, s_ready low the next cycle. A write already registered from the prior cycle still completes; no further writes occur.
  - abort and an accept in the same cycle: abort wins and the byte is not written.
  - In IDLE: abort is ignored, so start with abort in IDLE starts a load.
- start while busy: ignored.
- done and error are never high from the same load.

Optional Feature:
- Macro: CH8_LOADER_CHECKSUM_EN.
- With the macro:
  - An 8-bit running sum (mod 256) of payload bytes is kept; the CSUM state accepts one trailer byte.
  - Trailer == sum: -> DONE.
  - Trailer != sum: error <= 1, no done, -> IDLE. The payload remains in RAM.
- Without the macro: no CSUM state and no sum register; the last payload accept goes directly to DONE.

Decomposition:
- Shared package chip8_pkg holds:
  - CH8_ADDR_W = 12, CH8_PROG_BASE = 12'h200, CH8_RAM_SIZE = 4096.
  - The loader state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE).
- No sub-module is needed; the FSM, index counter, write register stage and checksum fit one module.
- The RAM itself stays in the top as a dual-use array: the loader owns the write port, and the CPU owns reads while cpu_hold = 0.

Test Plan:
- Load 00 03 A2 2A 60: writes A2@0x200, 2A@0x201, 60@0x202 on consecutive cycles after each accept; done pulses once; load_len = 3; cpu_hold falls after done.
- s_valid toggling every other cycle with length 4: exactly 4 writes at 0x200..0x203, no duplicate or dropped bytes, s_ready never high in DONE.
- Header 0E 01 (3585 > MAX_LEN): error = 1, no ram_we, back to IDLE. Header 00 00: same result.
- abort asserted on the 2nd payload accept of length 5: only 0x200 is written, error = 1, done never pulses, the next start clears error.
- Reset asserted mid-DATA: ram_we, busy, cpu_hold, s_ready and done are 0 immediately, without waiting for a clock edge.
- With CH8_LOADER_CHECKSUM_EN: payload 01 02 with trailer 03 -> done pulses; trailer 04 -> error = 1, no done, RAM still holds 01 02.
